// File: rtl/monitor_motor.sv
// ============================================================================
// Module   : monitor_motor
// Purpose  : Watches the motor-controller code, times the GAS/ELECTRICO phase
//            and issues a held trip report. Optional macro: MONITOR_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module monitor_motor #(
   parameter int LIMITE_GAS   = 15,
   parameter int LIMITE_ELEC  = 20,
   parameter int WATCHDOG_MAX = 40
) (
   input  logic       CLK,
   input  logic       REINICIO,
   input  logic       MOTOR1,
   input  logic       MOTOR2,
   input  logic       REPORTE_ACK,
   output logic [1:0] MODO_ACTUAL,
   output logic [5:0] CICLOS,
   output logic       REPORTE_VALIDO,
   output logic       REPORTE_MODO,
   output logic       REPORTE_OK,
   output logic       ERROR
);

   localparam logic [1:0] CODE_INICIO = 2'b00;
   localparam logic [1:0] CODE_GAS    = 2'b01;
   localparam logic [1:0] CODE_ELEC   = 2'b10;
   localparam logic [1:0] CODE_FIN    = 2'b11;
   localparam logic [5:0] LIM_GAS     = 6'(LIMITE_GAS);
   localparam logic [5:0] LIM_ELEC    = 6'(LIMITE_ELEC);

   typedef enum logic [2:0] {
      ESPERA    = 3'd0,
      GAS       = 3'd1,
      ELECTRICO = 3'd2,
      FIN       = 3'd3,
      FALLA     = 3'd4
   } state_t;

   state_t     state, state_nx;
   logic [1:0] code;
   logic [5:0] ciclos_inc;
   logic [1:0] modo_nx;
   logic [5:0] ciclos_nx;
   logic       valido_nx, rmodo_nx, ok_nx, error_nx;
   logic       phase_timeout;

   assign code       = {MOTOR1, MOTOR2};
   assign ciclos_inc = (CICLOS == 6'd63) ? CICLOS : CICLOS + 6'd1;

`ifdef MONITOR_WATCHDOG_EN
   localparam logic [5:0] WD_MAX = 6'(WATCHDOG_MAX);
   assign phase_timeout = (ciclos_inc >= WD_MAX);
`else
   logic unused_watchdog;
   assign unused_watchdog = (WATCHDOG_MAX != 0);
   assign phase_timeout   = 1'b0;
`endif

   always_ff @(posedge CLK or posedge REINICIO) begin
      if (REINICIO) begin
         state          <= ESPERA;
         MODO_ACTUAL    <= 2'b00;
         CICLOS         <= 6'd0;
         REPORTE_VALIDO <= 1'b0;
         REPORTE_MODO   <= 1'b0;
         REPORTE_OK     <= 1'b0;
         ERROR          <= 1'b0;
      end else begin
         state          <= state_nx;
         MODO_ACTUAL    <= modo_nx;
         CICLOS         <= ciclos_nx;
         REPORTE_VALIDO <= valido_nx;
         REPORTE_MODO   <= rmodo_nx;
         REPORTE_OK     <= ok_nx;
         ERROR          <= error_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      modo_nx   = MODO_ACTUAL;
      ciclos_nx = CICLOS;
      valido_nx = REPORTE_VALIDO & ~REPORTE_ACK;
      rmodo_nx  = REPORTE_MODO;
      ok_nx     = REPORTE_OK;
      error_nx  = ERROR;

      case (state)
         ESPERA: begin
            case (code)
               CODE_INICIO: ;
               CODE_GAS: begin
                  state_nx  = GAS;
                  modo_nx   = 2'b01;
                  ciclos_nx = ciclos_inc;
               end
               CODE_ELEC: begin
                  state_nx  = ELECTRICO;
                  modo_nx   = 2'b10;
                  ciclos_nx = ciclos_inc;
               end
               default: state_nx = FALLA;
            endcase
         end
         GAS: begin
            if (code == CODE_GAS) begin
               ciclos_nx = ciclos_inc;
               if (phase_timeout) state_nx = FALLA;
            end else if (code == CODE_FIN) begin
               state_nx  = FIN;
               modo_nx   = 2'b11;
               valido_nx = 1'b1;
               rmodo_nx  = 1'b0;
               ok_nx     = (CICLOS == LIM_GAS);
            end else begin
               state_nx = FALLA;
            end
         end
         ELECTRICO: begin
            if (code == CODE_ELEC) begin
               ciclos_nx = ciclos_inc;
               if (phase_timeout) state_nx = FALLA;
            end else if (code == CODE_FIN) begin
               state_nx  = FIN;
               modo_nx   = 2'b11;
               valido_nx = 1'b1;
               rmodo_nx  = 1'b1;
               ok_nx     = (CICLOS == LIM_ELEC);
            end else begin
               state_nx = FALLA;
            end
         end
         FIN: begin
            if (code != CODE_FIN) state_nx = FALLA;
         end
         FALLA:   state_nx = FALLA;
         default: state_nx = FALLA;
      endcase

      // Any path into FALLA latches the error and withdraws a pending report.
      if (state_nx == FALLA) begin
         error_nx  = 1'b1;
         valido_nx = 1'b0;
      end
   end

endmodule

`default_nettype wire
